// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that drives the select of an N:1 mux so that N valid/ready
// sources can share one valid/ready sink. A grant is held until its transfer completes.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   req_valid[N]         per-requester valid
//   req_data[N*W]        requester k data in bits [k*W +: W]
//   req_ready[N]         per-requester ready (only the granted bit may be set)
//   out_valid/out_data   shared sink channel (mux output)
//   out_ready            shared sink ready
//   grant[N]             registered one-hot grant, zero when idle
//   sel[SEL_W]           registered mux select (index of granted requester)
module mux_rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] sel
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [W-1:0]     data_arr [N];
  logic [SEL_W-1:0] arb_base;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             xfer;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign data_arr[k] = req_data[k*W +: W];
  end

  // Idle arbitration continues after the last served requester; a completing
  // transfer rotates from the current owner, which equals the new last.
  assign arb_base = (state_q == StBusy) ? sel_q : last_q;
  assign xfer     = (state_q == StBusy) && req_valid[sel_q] && out_ready;

  // First valid requester scanning base+1, base+2, ... modulo N (base itself last).
  always_comb begin
    int unsigned idx;
    logic [SEL_W-1:0] idx_s;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_s      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx   = (int'(arb_base) + i) % N;
      idx_s = SEL_W'(idx);
      if (!pick_found && req_valid[idx_s]) begin
        pick_found = 1'b1;
        pick_idx   = idx_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StBusy;
          sel_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      StBusy: begin
        if (xfer) begin
          last_d = sel_q;
          if (pick_found) begin
            sel_d             = pick_idx;
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end else if (!req_valid[sel_q]) begin
          // Owner withdrew its request: release without touching priority.
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: combinational from registered sel and state
  always_comb begin
    req_ready = '0;
    out_valid = 1'b0;
    out_data  = data_arr[sel_q];
    if (state_q == StBusy) begin
      out_valid        = req_valid[sel_q];
      req_ready[sel_q] = out_ready;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned SEL_W = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the channel (if anyone) and who was served last.
  bit m_busy;
  int m_owner;
  int m_last;

  mux_rr_arbiter #(.N(N), .W(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int base);
    for (int k = 1; k <= int'(N); k++) begin
      int idx;
      idx = (base + k) % int'(N);
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] data_of(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic r);
    int w;
    if (!m_busy) begin
      w = pick(v, m_last);
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
      end
    end else if (v[m_owner] && r) begin
      m_last = m_owner;
      w = pick(v, m_owner);
      if (w >= 0) m_owner = w;
      else m_busy = 1'b0;
    end else if (!v[m_owner]) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
    exp_grant = '0;
    exp_ready = '0;
    if (m_busy) begin
      exp_grant[m_owner] = 1'b1;
      exp_ready[m_owner] = out_ready;
    end
    check_eq("grant", 32'(grant), 32'(exp_grant));
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("out_valid", 32'(out_valid), 32'(m_busy && req_valid[m_owner]));
    if (m_busy) begin
      check_eq("sel", 32'(sel), 32'(m_owner));
      check_eq("out_data", 32'(out_data), 32'(data_of(req_data, m_owner)));
    end
  endtask

  // Called at posedge+1; applies inputs, checks mid-cycle, advances across one edge.
  task automatic drive_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
    req_valid = v;
    req_data  = d;
    out_ready = r;
    #4;
    compare_model();
    @(posedge clk);
    model_step(v, r);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    out_ready = 1'b0;
    req_data  = $urandom;
    rst_n     = 1'b0;
    model_reset();
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'(req_data[W-1:0]));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*W-1:0] d;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    #12;
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      drive_cycle(4'b0000, 32'h1234_5678, 1'b1);
      check_eq("idle_sel", 32'(sel), 32'd0);
    end

    // Single requester
    d = 32'h00A5_0000;
    drive_cycle(4'b0100, d, 1'b1);
    check_eq("single_grant", 32'(grant), 32'h4);
    check_eq("single_sel", 32'(sel), 32'd2);
    check_eq("single_data", 32'(out_data), 32'hA5);
    check_eq("single_ready", 32'(req_ready), 32'h4);
    check_eq("single_valid", 32'(out_valid), 32'd1);

    // Fairness, back-to-back
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_cycle(4'b1111, $urandom, 1'b1);
      check_eq("fair_grant", 32'(grant), 32'(1 << (k % 4)));
    end

    // Backpressure lock
    do_reset();
    drive_cycle(4'b0010, $urandom, 1'b0);
    check_eq("bp_first", 32'(grant), 32'h2);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(4'b0011, $urandom, 1'b0);
      check_eq("bp_hold", 32'(grant), 32'h2);
    end
    drive_cycle(4'b0111, $urandom, 1'b1);
    check_eq("bp_next", 32'(grant), 32'h4);
    drive_cycle(4'b0011, $urandom, 1'b0);

    // Sole requester equal to last wins repeatedly
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(4'b1000, $urandom, 1'b1);
      check_eq("sole_grant", 32'(grant), 32'h8);
    end
    drive_cycle(4'b0001, $urandom, 1'b1);
    check_eq("sole_to_idle", 32'(grant), 32'h0);
    drive_cycle(4'b0001, $urandom, 1'b1);
    check_eq("wrap_grant", 32'(grant), 32'h1);

    // Valid drop while granted
    do_reset();
    drive_cycle(4'b0010, $urandom, 1'b0);
    drive_cycle(4'b0000, $urandom, 1'b1);
    check_eq("drop_idle", 32'(grant), 32'h0);

    // Asynchronous reset between edges
    drive_cycle(4'b0001, $urandom, 1'b0);
    check_eq("pre_rst_grant", 32'(grant), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_grant", 32'(grant), 32'h0);
    check_eq("async_valid", 32'(out_valid), 32'h0);
    check_eq("async_ready", 32'(req_ready), 32'h0);
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_cycle(N'($urandom), $urandom, ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares one W-bit output channel between N requesters by sequencing the select of an N:1 mux.
- Each requester has a valid/ready source port. The shared output is a valid/ready sink.
- Round-robin priority guarantees fairness. A grant is held until its transfer completes.
- Sits in front of any single-consumer resource (shared bus, display/sound sink) that several producers must drive.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, data width per requester
- SEL_W, $clog2(N), width of mux select (derived, not overridden)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester valid; bit k = requester k
- req_data  input  N*W  requester k data in bits [k*W +: W]
- req_ready  output  N  per-requester ready (one-hot or zero)
- out_valid  output  1  shared channel valid
- out_data  output  W  shared channel data (mux output)
- out_ready  input  1  shared channel ready from consumer
- grant  output  N  registered one-hot grant vector, 0 when idle
- sel  output  SEL_W  registered mux select = index of granted requester

Behaviour:
- Reset (asynchronous assertion, synchronous release) sets:
  - state=IDLE, grant=0, sel=0, last=N-1
  - out_valid=0, req_ready=0, out_data=req_data[0 +: W]
- last=N-1 at reset means requester 0 has top priority after reset.
- States: IDLE, BUSY.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning last+1, last+2, ... wrapping modulo N.
  - Register grant/sel to that index and go to BUSY next edge. Otherwise stay in IDLE.
- BUSY outputs (combinational from registered sel):
  - out_valid = req_valid[sel]
  - out_data = req_data[sel]
  - req_ready[sel] = out_ready; all other req_ready bits are 0
- Transfer = out_valid && out_ready in BUSY. On a transfer edge:
  - last <= sel.
  - If any req_valid is set (including the current requester), pick the next winner scanning from sel+1 and stay in BUSY with the new grant. This gives back-to-back transfers with no bubble.
  - Otherwise go to IDLE with grant=0.
- Grant lock: while BUSY and no transfer, grant/sel are unchanged even if higher-priority requests arrive.
- Requester drops valid while granted (protocol violation, tolerated): out_valid falls to 0 the same cycle. Next edge goes to IDLE, last unchanged, no data lost or duplicated.
- Latency: request arriving in IDLE at edge t gives out_valid=1 during the cycle after edge t+1 (one registered arbitration cycle).
- Throughput: 1 transfer/cycle while requests are pending.
- Wrap-around: scan index wraps N-1 -> 0. A sole requester equal to last wins again.
- Simultaneous: a new request arriving in the same cycle as a transfer is considered in that cycle's arbitration.
- out_ready deasserted: the granted requester waits indefinitely. Consumer backpressure is never converted into a grant change.
- Reset mid-transfer: all outputs drop to reset values immediately (asynchronous); the in-flight transfer is abandoned.
- req_ready never has more than one bit set. grant and req_ready are always subsets of a one-hot vector.

Test Plan:
- Reset then idle: rst_n=0, then 1, all req_valid=0 -> grant=0, out_valid=0, req_ready=0, sel=0 for 10 cycles.
- Single requester: req_valid=4'b0100, req_data[2]=8'hA5, out_ready=1 -> next cycle grant=4'b0100, sel=2, out_data=8'hA5, req_ready=4'b0100, out_valid=1.
- Fairness: all four valid continuously, out_ready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no bubbles.
- Backpressure lock: grant=4'b0010, out_ready=0 for 5 cycles while req_valid[0] rises -> grant stays 0010, req_ready=0. After out_ready=1 (one transfer) -> next grant is 4'b0100 if req_valid[2]=1, else 4'b0001.
- Wrap/sole repeat: only requester 3 valid for 3 transfers -> grant=1000 each time, 3 transfers back-to-back. Then requester 0 valid -> grant=0001.
- Valid drop and async reset: granted requester 1 drops valid -> out_valid=0 same cycle, IDLE next cycle. Assert rst_n=0 mid-BUSY between edges -> grant=0 and out_valid=0 before the next clock edge.
